// File: rtl/sm83_pkg.sv
// Shared SM83 types: flags, wide-ALU opcodes, FSM states and the slice operation class.
// W_ADDS is only decoded as legal when ALU_WIDE_SIGNED_IMM_EN is defined.
package sm83_pkg;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef enum logic [3:0] {
    W_ADD  = 4'd0,
    W_ADC  = 4'd1,
    W_SUB  = 4'd2,
    W_SBC  = 4'd3,
    W_AND  = 4'd4,
    W_OR   = 4'd5,
    W_XOR  = 4'd6,
    W_CP   = 4'd7,
    W_INC  = 4'd8,
    W_DEC  = 4'd9,
    W_ADDS = 4'd10
  } alu_w_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_w_state_t;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ARITH = 3'd1,
    CLS_AND   = 3'd2,
    CLS_OR    = 3'd3,
    CLS_XOR   = 3'd4
  } alu_cls_t;

  function automatic alu_cls_t op_class(alu_w_op_t op);
    case (op)
      W_ADD, W_ADC, W_SUB, W_SBC, W_CP, W_INC, W_DEC: op_class = CLS_ARITH;
      W_AND: op_class = CLS_AND;
      W_OR:  op_class = CLS_OR;
      W_XOR: op_class = CLS_XOR;
`ifdef ALU_WIDE_SIGNED_IMM_EN
      W_ADDS: op_class = CLS_ARITH;
`endif
      default: op_class = CLS_NONE;
    endcase
  endfunction

  // Ops whose carry chain carries a borrow rather than a carry.
  function automatic logic op_is_sub(alu_w_op_t op);
    op_is_sub = (op == W_SUB) || (op == W_SBC) || (op == W_CP) || (op == W_DEC);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational W-bit add/subtract/logic slice; also reports the chain value
// out of bit tap_i so the caller can pick up a half-carry inside the slice.
module alu_slice
  import sm83_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAP_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  input  alu_cls_t         cls_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic [W-1:0]     sum_o,
  output logic             cout_o,
  output logic             tap_o
);

  logic [W-1:0] arith;
  logic         chain;
  logic         tap;

  // Ripple chain; in subtract mode chain is a borrow (a - b - bin).
  always_comb begin
    chain = cin_i;
    arith = '0;
    tap   = 1'b0;
    for (int i = 0; i < W; i++) begin
      arith[i] = a_i[i] ^ b_i[i] ^ chain;
      if (sub_i)
        chain = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & chain);
      else
        chain = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & chain);
      if (i == int'(tap_i)) tap = chain;
    end
  end

  always_comb begin
    sum_o  = '0;
    cout_o = 1'b0;
    tap_o  = tap;
    case (cls_i)
      CLS_ARITH: begin
        sum_o  = arith;
        cout_o = chain;
      end
      CLS_AND: sum_o = a_i & b_i;
      CLS_OR:  sum_o = a_i | b_i;
      CLS_XOR: sum_o = a_i ^ b_i;
      default: sum_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_wide_seq.sv
// Multi-cycle WIDTH-bit SM83 ALU, one SLICE_W-bit slice per cycle LSB first.
// Define ALU_WIDE_SIGNED_IMM_EN to enable W_ADDS (op1 + sign-extended op2[7:0]).
module alu_wide_seq
  import sm83_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 8,
  parameter int H_BIT   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  alu_w_op_t          op,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  flags_t             in_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output flags_t             out_flags,
  output alu_w_state_t       dbg_state
);

  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int TAP_W   = (SLICE_W > 1) ? $clog2(SLICE_W) : 1;
  localparam int H_SLICE = H_BIT / SLICE_W;
  localparam int H_TAP   = H_BIT % SLICE_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);
  localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(H_SLICE);
  localparam logic [TAP_W-1:0] TAP_IDX  = TAP_W'(H_TAP);

  alu_w_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  alu_w_op_t        op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] res_q, res_d;
  flags_t           oflags_q, oflags_d;
  logic             nz_q, nz_d;
  logic             h_q, h_d;
`ifdef ALU_WIDE_SIGNED_IMM_EN
  logic             adds_h_q, adds_h_d;
  logic             adds_c_q, adds_c_d;
  logic [4:0]       lo_nib;
  logic [8:0]       lo_byte;
`endif

  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout, sl_tap;
  logic               h_now, z_now;

  assign sl_a = a_q[int'(cnt_q)*SLICE_W +: SLICE_W];
  assign sl_b = b_q[int'(cnt_q)*SLICE_W +: SLICE_W];

  alu_slice #(.W(SLICE_W), .TAP_W(TAP_W)) u_slice (
    .a_i   (sl_a),
    .b_i   (sl_b),
    .cin_i (carry_q),
    .sub_i (op_is_sub(op_q)),
    .cls_i (op_class(op_q)),
    .tap_i (TAP_IDX),
    .sum_o (sl_sum),
    .cout_o(sl_cout),
    .tap_o (sl_tap)
  );

  assign h_now = (cnt_q == CNT_H) ? sl_tap : h_q;
  assign z_now = ~(nz_q | (|sl_sum));

`ifdef ALU_WIDE_SIGNED_IMM_EN
  // ADDS flags always come from the low byte, independent of H_BIT and slicing.
  assign lo_nib  = {1'b0, op1[3:0]} + {1'b0, op2[3:0]};
  assign lo_byte = {1'b0, op1[7:0]} + {1'b0, op2[7:0]};
`endif

  // Handshake: a request transfers on in_valid && in_ready (IDLE only); a result
  // transfers on out_valid && out_ready (DONE only), and in_ready returns a cycle later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    flags_d  = flags_q;
    res_d    = res_q;
    oflags_d = oflags_q;
    nz_d     = nz_q;
    h_d      = h_q;
`ifdef ALU_WIDE_SIGNED_IMM_EN
    adds_h_d = adds_h_q;
    adds_c_d = adds_c_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = op;
          a_d     = op1;
          b_d     = op2;
          flags_d = in_flags;
          nz_d    = 1'b0;
          h_d     = 1'b0;
          case (op)
            W_ADC, W_SBC: carry_d = in_flags.c;
            W_INC, W_DEC: begin
              carry_d = 1'b1;
              b_d     = '0;
            end
`ifdef ALU_WIDE_SIGNED_IMM_EN
            W_ADDS: begin
              carry_d  = 1'b0;
              b_d      = WIDTH'($signed(op2[7:0]));
              adds_h_d = lo_nib[4];
              adds_c_d = lo_byte[8];
            end
`endif
            default: carry_d = 1'b0;
          endcase
        end
      end
      RUN: begin
        res_d[int'(cnt_q)*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        nz_d    = nz_q | (|sl_sum);
        if (cnt_q == CNT_H) h_d = sl_tap;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          case (op_q)
            W_ADD, W_ADC:       oflags_d = '{z: z_now, n: 1'b0, h: h_now, c: sl_cout};
            W_SUB, W_SBC, W_CP: oflags_d = '{z: z_now, n: 1'b1, h: h_now, c: sl_cout};
            W_AND:              oflags_d = '{z: z_now, n: 1'b0, h: 1'b1, c: 1'b0};
            W_OR, W_XOR:        oflags_d = '{z: z_now, n: 1'b0, h: 1'b0, c: 1'b0};
            W_INC, W_DEC:       oflags_d = flags_q;
`ifdef ALU_WIDE_SIGNED_IMM_EN
            W_ADDS:             oflags_d = '{z: 1'b0, n: 1'b0, h: adds_h_q, c: adds_c_q};
`endif
            default:            oflags_d = '0;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= W_ADD;
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      res_q    <= '0;
      oflags_q <= '0;
      nz_q     <= 1'b0;
      h_q      <= 1'b0;
`ifdef ALU_WIDE_SIGNED_IMM_EN
      adds_h_q <= 1'b0;
      adds_c_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      flags_q  <= flags_d;
      res_q    <= res_d;
      oflags_q <= oflags_d;
      nz_q     <= nz_d;
      h_q      <= h_d;
`ifdef ALU_WIDE_SIGNED_IMM_EN
      adds_h_q <= adds_h_d;
      adds_c_q <= adds_c_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign out_flags = oflags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq at WIDTH=16, SLICE_W=8, H_BIT=11; expected
// {flags,result} pairs are hand-computed and queued in exp_q.
module tb_alu_wide_seq;
  import sm83_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  alu_w_op_t    op;
  logic [15:0]  op1;
  logic [15:0]  op2;
  flags_t       in_flags;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  result;
  flags_t       out_flags;
  alu_w_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  alu_wide_seq #(.WIDTH(16), .SLICE_W(8), .H_BIT(11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .op1      (op1),
    .op2      (op2),
    .in_flags (in_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_flags(out_flags),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input alu_w_op_t o, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f);
    in_valid = 1'b1;
    op       = o;
    op1      = a;
    op2      = b;
    in_flags = f;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid, bounded.
  task automatic wait_out(input string tag);
    int cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, cyc, 2);
  endtask

  task automatic check_out(input string tag);
    logic [19:0] e;
    e = exp_q.pop_front();
    check({tag, "_res"}, result, e[15:0]);
    check({tag, "_flg"}, out_flags, e[19:16]);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rdy"}, {in_ready, out_valid}, 2'b10);
  endtask

  task automatic run_op(input string tag, input alu_w_op_t o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f,
                        input logic [15:0] er, input logic [3:0] ef);
    exp_q.push_back({ef, er});
    @(negedge clk);
    drive_req(o, a, b, f);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(tag);
    check_out(tag);
    handshake(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = W_ADD;
    op1       = '0;
    op2       = '0;
    in_flags  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 16'h0000);
    check("rst_flags", out_flags, 4'b0000);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_h",   W_ADD, 16'h0FFF, 16'h0001, 4'b0000, 16'h1000, 4'b0010);
    run_op("sub_h",   W_SUB, 16'h1000, 16'h0001, 4'b0000, 16'h0FFF, 4'b0110);
    run_op("sub_uf",  W_SUB, 16'h0000, 16'h0001, 4'b0000, 16'hFFFF, 4'b0111);
    run_op("adc_z",   W_ADC, 16'hFFFF, 16'h0000, 4'b0001, 16'h0000, 4'b1011);
    run_op("inc",     W_INC, 16'hFFFF, 16'h5555, 4'b1010, 16'h0000, 4'b1010);
    run_op("dec",     W_DEC, 16'h0000, 16'h1234, 4'b0101, 16'hFFFF, 4'b0101);
    run_op("and",     W_AND, 16'hF0F0, 16'h0FF0, 4'b0000, 16'h00F0, 4'b0010);
    run_op("and_z",   W_AND, 16'h00FF, 16'hFF00, 4'b0000, 16'h0000, 4'b1010);
    run_op("or",      W_OR,  16'h1200, 16'h0034, 4'b1111, 16'h1234, 4'b0000);
    run_op("xor_z",   W_XOR, 16'hAAAA, 16'hAAAA, 4'b0000, 16'h0000, 4'b1000);
    run_op("cp_eq",   W_CP,  16'h1234, 16'h1234, 4'b0000, 16'h0000, 4'b1100);
    run_op("sbc",     W_SBC, 16'h1000, 16'h0FFF, 4'b0001, 16'h0000, 4'b1110);
    run_op("add_c",   W_ADD, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b1001);
    run_op("undef",   alu_w_op_t'(4'hF), 16'h1234, 16'h4321, 4'b1111, 16'h0000, 4'b0000);
`ifdef ALU_WIDE_SIGNED_IMM_EN
    run_op("adds_neg", W_ADDS, 16'hFFF8, 16'h0008, 4'b0000, 16'h0000, 4'b0011);
    run_op("adds_m2",  W_ADDS, 16'h0005, 16'h00FE, 4'b1111, 16'h0003, 4'b0011);
`else
    run_op("adds_off", W_ADDS, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0000);
`endif

    // Backpressure: second request stays pending until the first result is taken.
    exp_q.push_back({4'b0000, 16'h2345});
    @(negedge clk);
    drive_req(W_ADD, 16'h1234, 16'h1111, 4'b0000);
    @(posedge clk); #1;
    drive_req(W_XOR, 16'hFFFF, 16'h0F0F, 4'b0000);
    wait_out("bp1");
    exp_q.push_back({4'b0000, 16'hF0F0});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", result, 16'h2345);
      check("bp_hold_flg", out_flags, 4'b0000);
      check("bp_hold_hs", {in_ready, out_valid}, 2'b01);
    end
    check_out("bp1");
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_reaccept", {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("bp2");
    check_out("bp2");
    handshake("bp2");

    // Asynchronous reset in the middle of RUN discards the operation.
    @(negedge clk);
    drive_req(W_ADD, 16'hFFFF, 16'hFFFF, 4'b0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_state", dbg_state, RUN);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_hs", {in_ready, out_valid}, 2'b10);
    check("mid_rst_res", result, 16'h0000);
    check("mid_rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", W_ADD, 16'h1234, 16'h1111, 4'b0000, 16'h2345, 4'b0000);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
